// File: rtl/hub75_row_capture_pkg.sv
// Shared types and sizing helpers for the HUB75 row capture path.
package hub75_row_capture_pkg;

  // HUB75 colour triplet as it appears on the connector: {B,G,R}.
  typedef struct packed {
    logic b;
    logic g;
    logic r;
  } rgb_t;

  // Drain FSM encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Debug view: FSM state plus the sampled blanking pin (observed, never acted on).
  typedef struct packed {
    state_e state;
    logic   blanked;
  } dbg_t;

  // Row select addresses half the panel: the lower half is driven on colour2.
  function automatic int row_width(input int rows);
    return $clog2(rows / 2);
  endfunction

  // Full pixel address space covers both halves.
  function automatic int addr_width(input int cols, input int rows);
    return $clog2(cols * rows);
  endfunction

  // Stored pixel word: lower-half colour above upper-half colour.
  function automatic logic [5:0] pack_pixel(input rgb_t c1, input rgb_t c2);
    return {c2, c1};
  endfunction

endpackage

// File: rtl/hub75_edge_sync.sv
// Registers every HUB75 pin once and detects rising edges of shift clock and latch.
module hub75_edge_sync #(
  parameter int ROW_W = 5
) (
  input  logic             i_clk,
  input  logic             rst,
  input  logic             hub_clk,
  input  logic             hub_latch,
  input  logic             hub_oe,
  input  logic [ROW_W-1:0] hub_row,
  input  logic [2:0]       hub_color1,
  input  logic [2:0]       hub_color2,
  output logic [ROW_W-1:0] s_row,
  output logic [2:0]       s_color1,
  output logic [2:0]       s_color2,
  output logic             s_oe,
  output logic             clk_rise,
  output logic             latch_rise
);

  logic s_clk, s_latch, p_clk, p_latch;

  // Sample stage s and the previous-sample stage p used for edge detection.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      s_clk    <= 1'b0;
      s_latch  <= 1'b0;
      s_oe     <= 1'b0;
      s_row    <= '0;
      s_color1 <= '0;
      s_color2 <= '0;
      p_clk    <= 1'b0;
      p_latch  <= 1'b0;
    end else begin
      s_clk    <= hub_clk;
      s_latch  <= hub_latch;
      s_oe     <= hub_oe;
      s_row    <= hub_row;
      s_color1 <= hub_color1;
      s_color2 <= hub_color2;
      p_clk    <= s_clk;
      p_latch  <= s_latch;
    end
  end

  assign clk_rise   = s_clk & ~p_clk;
  assign latch_rise = s_latch & ~p_latch;

endmodule

// File: rtl/hub75_row_capture.sv
// Rebuilds latched HUB75 rows and streams them out as pixel writes.
// Write handshake: o_wr_valid/o_wr_addr/o_wr_data are held stable while
// o_wr_valid is high and i_wr_ready is low; a beat transfers on a cycle
// where both are high. Valid never drops without a transfer except on rst.
module hub75_row_capture
  import hub75_row_capture_pkg::*;
#(
  parameter int MATRIX_COLS = 96,
  parameter int MATRIX_ROWS = 48
) (
  input  logic                                          i_clk,
  input  logic                                          rst,
  input  logic                                          i_hub_clk,
  input  logic                                          i_hub_latch,
  input  logic                                          i_hub_oe,
  input  logic [row_width(MATRIX_ROWS)-1:0]             i_hub_row,
  input  logic [2:0]                                    i_hub_color1,
  input  logic [2:0]                                    i_hub_color2,
  output logic                                          o_wr_valid,
  input  logic                                          i_wr_ready,
  output logic [addr_width(MATRIX_COLS, MATRIX_ROWS)-1:0] o_wr_addr,
  output logic [5:0]                                    o_wr_data,
  output logic                                          o_row_done,
  output logic                                          o_frame_done,
  output logic                                          o_err_len,
  output logic                                          o_overrun,
  output dbg_t                                          o_dbg
);

  localparam int ROW_W  = row_width(MATRIX_ROWS);
  localparam int ADDR_W = addr_width(MATRIX_COLS, MATRIX_ROWS);
  localparam int COL_W  = $clog2(MATRIX_COLS + 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(MATRIX_COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MATRIX_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MATRIX_ROWS / 2 - 1);

  logic [ROW_W-1:0] s_row;
  logic [2:0]       s_color1, s_color2;
  logic             s_oe, clk_rise, latch_rise;

  hub75_edge_sync #(.ROW_W(ROW_W)) u_sync (
    .i_clk      (i_clk),
    .rst        (rst),
    .hub_clk    (i_hub_clk),
    .hub_latch  (i_hub_latch),
    .hub_oe     (i_hub_oe),
    .hub_row    (i_hub_row),
    .hub_color1 (i_hub_color1),
    .hub_color2 (i_hub_color2),
    .s_row      (s_row),
    .s_color1   (s_color1),
    .s_color2   (s_color2),
    .s_oe       (s_oe),
    .clk_rise   (clk_rise),
    .latch_rise (latch_rise)
  );

  logic [5:0]       cap_buf   [MATRIX_COLS];
  logic [5:0]       drain_buf [MATRIX_COLS];
  logic [COL_W-1:0] col_q, idx_q, cap_idx;
  logic [ROW_W-1:0] row_q;
  logic             cap_we, load, accept, last;
  state_e           state_q, state_d;

  // A latch edge wins over a coincident shift edge: the shift lands in column 0 of the new row.
  assign cap_idx = latch_rise ? '0 : col_q;
  assign cap_we  = !rst && clk_rise && (latch_rise || (col_q != COL_FULL));

  // Column counter and sticky length error.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      col_q     <= '0;
      o_err_len <= 1'b0;
    end else if (latch_rise) begin
      if (col_q != COL_FULL) o_err_len <= 1'b1;
      col_q <= clk_rise ? COL_W'(1) : '0;
    end else if (clk_rise) begin
      if (col_q == COL_FULL) o_err_len <= 1'b1;
      else                   col_q <= col_q + COL_W'(1);
    end
  end

  // Capture buffer: one pixel pair per shift edge, extra columns dropped.
  always_ff @(posedge i_clk) begin
    if (cap_we) cap_buf[cap_idx] <= pack_pixel(rgb_t'(s_color1), rgb_t'(s_color2));
  end

  // Drain buffer snapshot taken when an idle FSM accepts a latch.
  always_ff @(posedge i_clk) begin
    if (load) drain_buf <= cap_buf;
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and per-cycle strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (latch_rise && !rst) begin
          load    = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        accept = i_wr_ready;
        last   = i_wr_ready && (idx_q == COL_LAST);
        if (last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Drain index, latched row and status pulses.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      idx_q        <= '0;
      row_q        <= '0;
      o_row_done   <= 1'b0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_row_done   <= last;
      o_frame_done <= last && (row_q == ROW_LAST);
      o_overrun    <= latch_rise && (state_q == ST_DRAIN);
      if (load) begin
        idx_q <= '0;
        row_q <= s_row;
      end else if (accept) begin
        idx_q <= last ? '0 : idx_q + COL_W'(1);
      end
    end
  end

  assign o_wr_valid    = (state_q == ST_DRAIN);
  assign o_wr_addr     = o_wr_valid ? (ADDR_W'(idx_q) + ADDR_W'(MATRIX_COLS) * ADDR_W'(row_q)) : '0;
  assign o_wr_data     = o_wr_valid ? drain_buf[idx_q] : '0;
  assign o_dbg.state   = state_q;
  assign o_dbg.blanked = s_oe;

endmodule
